// File: rtl/vseg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller with refresh prescaler,
// hex decode, per-digit blank/dp, leading-zero suppression and an anti-ghosting guard.
module vseg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int GUARD      = 0,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic [4*NUM_DIGITS-1:0]         digits,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic [NUM_DIGITS-1:0]           blank,
    input  logic                            lz_suppress,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [6:0]                      seg,
    output logic                            dp,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_start
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_LOAD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF     = ACTIVE_LOW;

    typedef enum logic [1:0] {ST_OFF, ST_GUARD, ST_DRIVE} drive_t;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      guard_cnt;
    logic [IDX_W-1:0]      idx_next;
    logic                  tick;
    drive_t                drive_state;
    logic [3:0]            nib;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    // Active-high {g,f,e,d,c,b,a}; b and d are the lower-case glyphs.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b0111111;
            4'h1: hex_to_seg = 7'b0000110;
            4'h2: hex_to_seg = 7'b1011011;
            4'h3: hex_to_seg = 7'b1001111;
            4'h4: hex_to_seg = 7'b1100110;
            4'h5: hex_to_seg = 7'b1101101;
            4'h6: hex_to_seg = 7'b1111101;
            4'h7: hex_to_seg = 7'b0000111;
            4'h8: hex_to_seg = 7'b1111111;
            4'h9: hex_to_seg = 7'b1101111;
            4'hA: hex_to_seg = 7'b1110111;
            4'hB: hex_to_seg = 7'b1111100;
            4'hC: hex_to_seg = 7'b0111001;
            4'hD: hex_to_seg = 7'b1011110;
            4'hE: hex_to_seg = 7'b1111001;
            default: hex_to_seg = 7'b1110001;
        endcase
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (digits[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_suppress & zero_run;
        end
    end

    always_comb begin
        tick     = en && (cnt == CNT_LAST);
        idx_next = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        nib      = digits[{digit_idx, 2'b00} +: 4];
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = DP_OFF;

        if (!en)
            drive_state = ST_OFF;
        else if (guard_cnt != '0)
            drive_state = ST_GUARD;
        else
            drive_state = ST_DRIVE;

        if (drive_state == ST_DRIVE) begin
            an_next  = ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx) ^ AN_OFF;
            seg_next = ((blank[digit_idx] | lz_dark[digit_idx]) ? 7'b0000000 : hex_to_seg(nib))
                       ^ SEG_OFF;
            dp_next  = (dp_in[digit_idx] & ~blank[digit_idx]) ^ DP_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            digit_idx   <= '0;
            guard_cnt   <= '0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            frame_start <= 1'b0;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
            if (tick) begin
                cnt         <= '0;
                digit_idx   <= idx_next;
                guard_cnt   <= GUARD_LOAD;
                frame_start <= (idx_next == '0);
            end else begin
                frame_start <= 1'b0;
                if (en) begin
                    cnt <= cnt + 1'b1;
                    if (drive_state == ST_GUARD)
                        guard_cnt <= guard_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vseg_scan_ctrl.sv
// Directed bench for vseg_scan_ctrl with 4 digits, 4-cycle slots, 1 guard cycle,
// active-low outputs; expected values are written out by hand per step.
module tb_vseg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_suppress;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    vseg_scan_ctrl #(
        .NUM_DIGITS(4),
        .CLK_DIV(4),
        .GUARD(1),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .digits(digits),
        .dp_in(dp_in),
        .blank(blank),
        .lz_suppress(lz_suppress),
        .an(an),
        .seg(seg),
        .dp(dp),
        .digit_idx(digit_idx),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv,
                                 input logic [3:0] bl, input logic lz);
        digits      = d;
        dp_in       = dpv;
        blank       = bl;
        lz_suppress = lz;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                               input logic e_dp, input logic [1:0] e_idx, input logic e_fs);
        checks++;
        assert (an === e_an) else begin
            errors++;
            $error("[TB] FAIL %s an: observed %b expected %b", tag, an, e_an);
        end
        checks++;
        assert (seg === e_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg: observed %b expected %b", tag, seg, e_seg);
        end
        checks++;
        assert (dp === e_dp) else begin
            errors++;
            $error("[TB] FAIL %s dp: observed %b expected %b", tag, dp, e_dp);
        end
        checks++;
        assert (digit_idx === e_idx) else begin
            errors++;
            $error("[TB] FAIL %s digit_idx: observed %0d expected %0d", tag, digit_idx, e_idx);
        end
        checks++;
        assert (frame_start === e_fs) else begin
            errors++;
            $error("[TB] FAIL %s frame_start: observed %b expected %b", tag, frame_start, e_fs);
        end
    endtask

    // Called just before the guard edge of a slot: one dark cycle, three lit cycles,
    // and digit_idx advances on the last edge.
    task automatic runSlot(input string tag, input logic [1:0] idx, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
        logic [1:0] nxt;
        nxt = idx + 2'd1;
        step();
        checkOutput({tag, "_guard"}, 4'b1111, 7'b1111111, 1'b1, idx, 1'b0);
        step();
        checkOutput({tag, "_lit1"}, e_an, e_seg, e_dp, idx, 1'b0);
        step();
        checkOutput({tag, "_lit2"}, e_an, e_seg, e_dp, idx, 1'b0);
        step();
        checkOutput({tag, "_end"}, e_an, e_seg, e_dp, nxt, (nxt == 2'd0));
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b0);

        // Reset, then the first slot has no guard cycle since guard_cnt starts at 0.
        step();
        step();
        checkOutput("reset", 4'b1111, 7'b1111111, 1'b1, 2'd0, 1'b0);
        reset = 1'b0;
        step();
        checkOutput("first_drive", 4'b1110, 7'b1000000, 1'b1, 2'd0, 1'b0);
        step();
        checkOutput("slot0_c1", 4'b1110, 7'b1000000, 1'b1, 2'd0, 1'b0);
        step();
        checkOutput("slot0_c2", 4'b1110, 7'b1000000, 1'b1, 2'd0, 1'b0);
        step();
        checkOutput("slot0_end", 4'b1110, 7'b1000000, 1'b1, 2'd1, 1'b0);
        runSlot("zero_s1", 2'd1, 4'b1101, 7'b1000000, 1'b1);
        runSlot("zero_s2", 2'd2, 4'b1011, 7'b1000000, 1'b1);
        runSlot("zero_s3", 2'd3, 4'b0111, 7'b1000000, 1'b1);
        runSlot("zero_s0", 2'd0, 4'b1110, 7'b1000000, 1'b1);

        // Mixed hex digits with a decimal point on digit 2.
        applyStimulus(16'h8A10, 4'b0100, 4'b0000, 1'b0);
        runSlot("hex_s1", 2'd1, 4'b1101, 7'b1111001, 1'b1);
        runSlot("hex_s2", 2'd2, 4'b1011, 7'b0001000, 1'b0);
        runSlot("hex_s3", 2'd3, 4'b0111, 7'b0000000, 1'b1);
        runSlot("hex_s0", 2'd0, 4'b1110, 7'b1000000, 1'b1);

        // Leading-zero suppression keeps the dp of a suppressed digit.
        applyStimulus(16'h0005, 4'b0010, 4'b0000, 1'b1);
        runSlot("lz_s1", 2'd1, 4'b1101, 7'b1111111, 1'b0);
        runSlot("lz_s2", 2'd2, 4'b1011, 7'b1111111, 1'b1);
        runSlot("lz_s3", 2'd3, 4'b0111, 7'b1111111, 1'b1);
        runSlot("lz_s0", 2'd0, 4'b1110, 7'b0010010, 1'b1);
        applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
        runSlot("lz0_s1", 2'd1, 4'b1101, 7'b1111111, 1'b1);
        runSlot("lz0_s2", 2'd2, 4'b1011, 7'b1111111, 1'b1);
        runSlot("lz0_s3", 2'd3, 4'b0111, 7'b1111111, 1'b1);
        runSlot("lz0_s0", 2'd0, 4'b1110, 7'b1000000, 1'b1);

        // Explicit blank darkens both segments and dp of digit 0.
        applyStimulus(16'h1234, 4'b0001, 4'b0001, 1'b0);
        runSlot("blk_s1", 2'd1, 4'b1101, 7'b0110000, 1'b1);
        runSlot("blk_s2", 2'd2, 4'b1011, 7'b0100100, 1'b1);
        runSlot("blk_s3", 2'd3, 4'b0111, 7'b1111001, 1'b1);
        runSlot("blk_s0", 2'd0, 4'b1110, 7'b1111111, 1'b1);

        // Freeze mid-slot at cnt=2, then resume for the remaining two cycles.
        step();
        checkOutput("en_guard", 4'b1111, 7'b1111111, 1'b1, 2'd1, 1'b0);
        step();
        checkOutput("en_lit", 4'b1101, 7'b0110000, 1'b1, 2'd1, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checkOutput($sformatf("en_off%0d", k), 4'b1111, 7'b1111111, 1'b1, 2'd1, 1'b0);
        end
        en = 1'b1;
        step();
        checkOutput("en_resume1", 4'b1101, 7'b0110000, 1'b1, 2'd1, 1'b0);
        step();
        checkOutput("en_resume2", 4'b1101, 7'b0110000, 1'b1, 2'd2, 1'b0);

        // Reset in the middle of slot 2 restarts at digit 0 with everything dark.
        step();
        checkOutput("rst_guard", 4'b1111, 7'b1111111, 1'b1, 2'd2, 1'b0);
        step();
        checkOutput("rst_lit", 4'b1011, 7'b0100100, 1'b1, 2'd2, 1'b0);
        reset = 1'b1;
        step();
        checkOutput("rst_mid", 4'b1111, 7'b1111111, 1'b1, 2'd0, 1'b0);
        reset = 1'b0;
        step();
        checkOutput("rst_after1", 4'b1110, 7'b1111111, 1'b1, 2'd0, 1'b0);
        step();
        step();
        step();
        checkOutput("rst_after_end", 4'b1110, 7'b1111111, 1'b1, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
